// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single-cycle memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise the data port has fixed priority.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    // state | meaning
    // IDLE  | waiting for an eligible request; memory port holds, m_we low
    // GNT_I | instruction address on memory port for one cycle
    // GNT_D | data read/write on memory port for one cycle
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t state;
    logic   i_elig;
    logic   d_elig;
    logic   pick_i;
    logic   pick_d;

    // A port whose ack is high this cycle must not be regranted on its still-held request.
    assign i_elig = i_req & ~i_ack;
    assign d_elig = d_req & ~d_ack;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;

    assign pick_d = d_elig & (~i_elig | ~last_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d <= 1'b1;
        end else if (state == IDLE && (pick_i || pick_d)) begin
            last_d <= pick_d;
        end
    end
`else
    assign pick_d = d_elig;
`endif

    assign pick_i = i_elig & ~pick_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    m_we <= 1'b0;
                    if (pick_d) begin
                        m_addr  <= d_addr;
                        m_we    <= d_we;
                        m_wdata <= d_wdata;
                        state   <= GNT_D;
                    end else if (pick_i) begin
                        m_addr <= i_addr;
                        state  <= GNT_I;
                    end
                end
                GNT_I: begin
                    i_rdata <= m_rdata;
                    i_ack   <= 1'b1;
                    m_we    <= 1'b0;
                    state   <= IDLE;
                end
                GNT_D: begin
                    if (!m_we) begin
                        d_rdata <= m_rdata;
                    end
                    d_ack <= 1'b1;
                    m_we  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    m_we  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32: address width of both requester ports and the memory port.
REQ-002 Parameter DW, default 32: data width of both requester ports and the memory port.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 i_req  input  1  instruction-fetch request; held high with i_addr stable until i_ack.
REQ-006 i_addr  input  AW  instruction-fetch address.
REQ-007 i_rdata  output  DW  fetched word, registered; valid with i_ack and held until the next i_ack.
REQ-008 i_ack  output  1  one-cycle completion pulse for the instruction port.
REQ-009 d_req  input  1  data request; held high with d_we/d_addr/d_wdata stable until d_ack.
REQ-010 d_we  input  1  data request is a write (1) or a read (0).
REQ-011 d_addr  input  AW  data address.
REQ-012 d_wdata  input  DW  data write value.
REQ-013 d_rdata  output  DW  data read value, registered; valid with d_ack on reads and held until the next d_ack.
REQ-014 d_ack  output  1  one-cycle completion pulse for the data port.
REQ-015 m_we  output  1  memory write enable, registered.
REQ-016 m_addr  output  AW  memory address, registered.
REQ-017 m_wdata  output  DW  memory write data, registered.
REQ-018 m_rdata  input  DW  memory read data; combinational from m_addr within the same cycle.

Function
REQ-019 The FSM SHALL have three states: IDLE, GNT_I and GNT_D.
REQ-020 In IDLE with at least one eligible request, the winner's address, write-enable and write data SHALL be captured into m_addr/m_we/m_wdata, and the FSM SHALL move to GNT_<winner>.
REQ-021 An instruction grant SHALL always drive m_we=0.
REQ-022 A data grant SHALL drive m_we=d_we.
REQ-023 GNT_x SHALL last exactly one cycle.
REQ-024 At the end of GNT_x, m_rdata SHALL be registered into x_rdata, x_ack SHALL pulse for the following cycle, m_we SHALL clear, and the FSM SHALL return to IDLE.
REQ-025 On a data write, d_rdata SHALL be left unchanged.
REQ-026 Latency from a request first seen in IDLE to its ack SHALL be 2 cycles when uncontended.
REQ-027 The losing requester SHALL wait no more than 3 additional cycles.
REQ-028 A request SHALL be ineligible in the cycle its own ack is high, so a held-high req is not regranted; it becomes eligible again in the next cycle.
REQ-029 In IDLE with no eligible request, outputs SHALL hold, with m_we=0.
REQ-030 The two ack outputs SHALL never be high in the same cycle.
REQ-031 Requester inputs changing during GNT_x SHALL have no effect on the transfer in progress.
REQ-032 With i_req=d_req=0 for any duration, the FSM SHALL remain in IDLE.

Reset
REQ-033 While rst=1, the FSM SHALL be in IDLE and all outputs 0: i_ack, d_ack, m_we, m_addr, m_wdata, i_rdata and d_rdata.
REQ-034 rst asserted during GNT_x SHALL abort the transfer: no ack, and m_we drops immediately so no memory write occurs at the next edge.
REQ-035 After rst deasserts, the first grant SHALL occur no earlier than the first rising edge with rst=0.
REQ-036 The round-robin pointer, when present, SHALL reset to "last granted = data".

Configuration
REQ-037 The macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-038 With ARB_ROUND_ROBIN_EN defined, simultaneous eligible requests SHALL be granted to the port not granted most recently, and a one-bit last-granted pointer SHALL update on each grant.
REQ-039 With ARB_ROUND_ROBIN_EN undefined, simultaneous eligible requests SHALL always be granted to the data port (fixed priority), and no pointer SHALL exist.

Verification
REQ-040 Scenario (reset): rst high for 3 cycles, then i_req=1, i_addr=0x4, memory word 4 = 0x1234 -> i_ack 2 cycles after i_req seen; i_rdata=0x1234 with i_ack; all outputs were 0 during reset.
REQ-041 Scenario (write then read): d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF -> m_we=1 for exactly one cycle, then d_ack; a following read of 0x10 returns d_rdata=0xDEADBEEF.
REQ-042 Scenario (contention): i_req and d_req rise in the same cycle and are held -> round-robin build: i_ack first, then d_ack 2 cycles later; fixed-priority build: d_ack first.
REQ-043 Scenario (back-to-back, REQ-028): i_req held high through 3 consecutive acks with no data traffic -> i_ack pulses every 3 cycles, never on consecutive cycles.
REQ-044 Scenario (reset mid-transfer): rst pulsed during GNT_D of a write to 0x20 holding 0x0 -> memory word 0x20 remains 0x0, no d_ack, FSM in IDLE.
REQ-045 Scenario (starvation, round-robin build): d_req held continuously while i_req is pulsed -> each i_req acked within 5 cycles.
